// File: rtl/timer_counter_pkg.sv
// Shared definitions for timer_counter: FSM encodings, register word offsets,
// CTRL field layout and MODE codes.
package timer_counter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Word offsets, decoded from addr[3:2]
  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] OFS_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Stored CTRL bits; packed so the layout matches the bus word bits[3:0]
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counter with one-shot / auto-reload modes and a
// maskable, registered interrupt request.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrl_t       ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic [1:0]  state, state_n;
  logic        pend, pend_n;

  logic [1:0]  sel;
  logic        cfg_write;
  logic        unused_addr_bits;

  assign sel              = addr[3:2];
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};
  // Only CTRL and PRESET writes touch state; COUNT and reserved writes are dropped
  assign cfg_write        = we && (sel == OFS_CTRL || sel == OFS_PRESET);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    ctrl_n   = ctrl;
    preset_n = preset;
    count_n  = count;
    state_n  = state;
    pend_n   = pend;

    if (cfg_write) begin
      // Bus write wins over whatever the FSM would have done on this edge.
      if (sel == OFS_CTRL) begin
        ctrl_n.en   = wdata[CTRL_EN_BIT];
        ctrl_n.mode = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        ctrl_n.im   = wdata[CTRL_IM_BIT];
      end else begin
        preset_n = wdata;
      end
      state_n = ST_IDLE;
      pend_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl.en) state_n = ST_LOAD;
        end
        ST_LOAD: begin
          count_n = preset;
          state_n = ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            state_n = ST_IDLE;
          end else if (count > 32'd1) begin
            count_n = count - 32'd1;
          end else begin
            count_n = 32'd0;
            pend_n  = 1'b1;
            state_n = ST_INT;
          end
        end
        ST_INT: begin
          state_n = ST_IDLE;
          // Reserved modes 10/11 fall through to one-shot behaviour.
          if (ctrl.mode == MODE_RELOAD) pend_n = 1'b0;
          else                          ctrl_n.en = 1'b0;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      ctrl   <= '{im: 1'b0, mode: MODE_ONESHOT, en: 1'b0};
      preset <= 32'd0;
      count  <= 32'd0;
      state  <= ST_IDLE;
      pend   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ctrl   <= ctrl_n;
      preset <= preset_n;
      count  <= count_n;
      state  <= state_n;
      pend   <= pend_n;
      // Registered from next-state values so irq tracks pend without extra lag
      irq    <= pend_n & ctrl_n.im;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (sel)
      OFS_CTRL:   rdata = ctrl_word(ctrl);
      OFS_PRESET: rdata = preset;
      OFS_COUNT:  rdata = count;
      OFS_RSVD:   rdata = 32'd0;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: vector table for the register map and
// one-shot run, hand sequences for reload, freeze, masking, reset and priority.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h required=0x%08h", name, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, let one posedge act, compare at the next negedge.
  task automatic step(input string name, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic r,
                      input logic [31:0] er, input logic ei);
    exp_t e;
    e.name  = name;
    e.rdata = er;
    e.irq   = ei;
    sb.push_back(e);
    addr  = a;
    we    = w;
    wdata = d;
    reset = r;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.name, "_rdata"}, rdata, e.rdata);
      check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
    end
    we    = 1'b0;
    reset = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [31:0] er, input logic ei);
    vec_t v;
    v.name = n; v.addr = a; v.we = w; v.wdata = d; v.exp_rdata = er; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Register map after reset, then a one-shot run with PRESET=3 (CTRL write = edge t)
    add_vec("rst_ctrl",    32'h0, 1'b0, 32'h0,      32'h0,  1'b0);
    add_vec("rst_preset",  32'h4, 1'b0, 32'h0,      32'h0,  1'b0);
    add_vec("rst_count",   32'h8, 1'b0, 32'h0,      32'h0,  1'b0);
    add_vec("rst_rsvd",    32'hC, 1'b0, 32'h0,      32'h0,  1'b0);
    add_vec("os_wr_pre",   32'h4, 1'b1, 32'h3,      32'h3,  1'b0);
    add_vec("os_wr_ctrl",  32'h0, 1'b1, 32'h9,      32'h9,  1'b0);
    add_vec("os_t1_load",  32'h8, 1'b0, 32'h0,      32'h0,  1'b0);
    add_vec("os_t2",       32'h8, 1'b0, 32'h0,      32'h3,  1'b0);
    add_vec("os_t3",       32'h8, 1'b0, 32'h0,      32'h2,  1'b0);
    add_vec("os_t4",       32'h8, 1'b0, 32'h0,      32'h1,  1'b0);
    add_vec("os_t5_int",   32'h8, 1'b0, 32'h0,      32'h0,  1'b1);
    add_vec("os_t6_encl",  32'h0, 1'b0, 32'h0,      32'h8,  1'b1);
    add_vec("os_t7_hold",  32'h0, 1'b0, 32'h0,      32'h8,  1'b1);
    add_vec("os_clr",      32'h0, 1'b1, 32'h8,      32'h8,  1'b0);
    add_vec("rsvd_wr",     32'hC, 1'b1, 32'hFFFF,   32'h0,  1'b0);
    add_vec("count_wr_id", 32'h8, 1'b1, 32'hFFFF,   32'h0,  1'b0);
    add_vec("pre_upper",   32'h4, 1'b1, 32'hA5A5_0003, 32'hA5A5_0003, 1'b0);
    add_vec("ctrl_upper",  32'h0, 1'b1, 32'hFFFF_FFF8, 32'h8, 1'b0);
    foreach (vecs[i])
      step(vecs[i].name, vecs[i].addr, vecs[i].we, vecs[i].wdata, 1'b0,
           vecs[i].exp_rdata, vecs[i].exp_irq);

    // Auto-reload, PRESET=2: pulses after t+4, t+9, t+14, each one cycle wide
    step("ar_wr_pre",  32'h4, 1'b1, 32'h2, 1'b0, 32'h2, 1'b0);
    step("ar_wr_ctrl", 32'h0, 1'b1, 32'hB, 1'b0, 32'hB, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      logic exp_pulse;
      exp_pulse = (k >= 4) && ((k - 4) % 5 == 0);
      step($sformatf("ar_k%0d", k), 32'h0, 1'b0, 32'h0, 1'b0, 32'hB, exp_pulse);
    end
    step("ar_stop", 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

    // Freeze: PRESET=10, stop with CTRL=0x8 while COUNT reads 6
    step("fz_wr_pre",  32'h4, 1'b1, 32'd10, 1'b0, 32'd10, 1'b0);
    step("fz_wr_ctrl", 32'h0, 1'b1, 32'h9,  1'b0, 32'h9,  1'b0);
    step("fz_k1",      32'h0, 1'b0, 32'h0,  1'b0, 32'h9,  1'b0);
    for (int k = 2; k <= 6; k++)
      step($sformatf("fz_k%0d", k), 32'h8, 1'b0, 32'h0, 1'b0, 32'(12 - k), 1'b0);
    step("fz_stop", 32'h0, 1'b1, 32'h8, 1'b0, 32'h8, 1'b0);
    check("fz_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    for (int k = 0; k < 3; k++)
      step($sformatf("fz_hold%0d", k), 32'h8, 1'b0, 32'h0, 1'b0, 32'd6, 1'b0);

    // PRESET=0 with IM=0: INT after t+3, pend set but irq masked
    step("p0_wr_pre",  32'h4, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    step("p0_wr_ctrl", 32'h0, 1'b1, 32'h1, 1'b0, 32'h1, 1'b0);
    step("p0_k1", 32'h0, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);
    check("p0_k1_pend", {31'd0, dut.pend}, 32'd0);
    step("p0_k2", 32'h0, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);
    check("p0_k2_pend", {31'd0, dut.pend}, 32'd0);
    step("p0_k3", 32'h0, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0);
    check("p0_k3_state", {30'd0, dut.state}, {30'd0, ST_INT});
    check("p0_k3_pend", {31'd0, dut.pend}, 32'd1);
    step("p0_k4", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("p0_k4_pend", {31'd0, dut.pend}, 32'd1);
    step("p0_clr", 32'h0, 1'b1, 32'h8, 1'b0, 32'h8, 1'b0);
    check("p0_clr_pend", {31'd0, dut.pend}, 32'd0);

    // COUNT write mid-count is ignored; reset mid-count clears everything
    step("cw_wr_pre",  32'h4, 1'b1, 32'd5, 1'b0, 32'd5, 1'b0);
    step("cw_wr_ctrl", 32'h0, 1'b1, 32'h9, 1'b0, 32'h9, 1'b0);
    step("cw_k1",      32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("cw_k2",      32'h8, 1'b0, 32'h0, 1'b0, 32'd5, 1'b0);
    step("cw_k3_wr",   32'h8, 1'b1, 32'hFFFF, 1'b0, 32'd4, 1'b0);
    step("cw_k4",      32'h8, 1'b0, 32'h0, 1'b0, 32'd3, 1'b0);
    step("rs_count",   32'h8, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    check("rs_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    check("rs_pend",  {31'd0, dut.pend}, 32'd0);
    step("rs_ctrl",    32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rs_preset",  32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // MODE=10 acts as one-shot; a CTRL write landing in INT keeps the written EN
    step("m2_wr_pre",  32'h4, 1'b1, 32'h1, 1'b0, 32'h1, 1'b0);
    step("m2_wr_ctrl", 32'h0, 1'b1, 32'hD, 1'b0, 32'hD, 1'b0);
    step("m2_k1",      32'h0, 1'b0, 32'h0, 1'b0, 32'hD, 1'b0);
    step("m2_k2",      32'h0, 1'b0, 32'h0, 1'b0, 32'hD, 1'b0);
    step("m2_k3_int",  32'h0, 1'b0, 32'h0, 1'b0, 32'hD, 1'b1);
    step("m2_k4_wr",   32'h0, 1'b1, 32'hD, 1'b0, 32'hD, 1'b0);
    check("m2_k4_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    step("m2_k5",      32'h0, 1'b0, 32'h0, 1'b0, 32'hD, 1'b0);
    step("m2_k6",      32'h0, 1'b0, 32'h0, 1'b0, 32'hD, 1'b0);
    step("m2_k7_int",  32'h0, 1'b0, 32'h0, 1'b0, 32'hD, 1'b1);
    step("m2_k8_encl", 32'h0, 1'b0, 32'h0, 1'b0, 32'hC, 1'b1);
    step("m2_stop",    32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
